// File: rtl/radix_2_pipe.sv
// radix_2_pipe: four-stage modular radix-2 butterfly over Z_q.
// select=0 computes a Cooley-Tukey (NTT) butterfly, select=1 a Gentleman-Sande
// (INTT) butterfly; scale=1 halves both results mod q. Each beat carries its
// own mode bits down the pipe, so modes may change on every beat.
//
// Handshake: a beat moves between two parties on a rising edge where valid and
// ready are both high. The whole pipe advances together when the output
// register is empty or being drained (out_valid=0 or out_ready=1); in_ready is
// exactly that advance condition, so it falls combinationally with out_ready.
module radix_2_pipe #(
    parameter int width     = 16,
    parameter int q         = 12289,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     input_1,
    input  logic [width-1:0]     input_2,
    input  logic [width-1:0]     input_twiddle,
    input  logic                 select,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     output_1,
    output logic [width-1:0]     output_2,
    output logic                 busy,
    output logic [cnt_width-1:0] beat_count
);

    // Modulus at the widths used by the add/sub and multiply paths.
    localparam int              pw     = 2 * width;
    localparam logic [width:0]  q_w1   = (width + 1)'(q);
    localparam logic [pw-1:0]   q_pw   = pw'(q);
    localparam logic [pw:0]     q_pw1  = (pw + 1)'(q);
    // Barrett constant m = floor(2^pw / q); the quotient estimate it gives is
    // at most two below the true quotient, hence two correction steps.
    localparam logic [pw:0]     two_k  = {1'b1, {pw{1'b0}}};
    localparam logic [pw-1:0]   barrett_m = pw'(two_k / q_pw1);

    // (x + y) mod q for x, y in [0,q).
    function automatic logic [width-1:0] mod_add(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [width:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= q_w1) s = s - q_w1;
        return width'(s);
    endfunction

    // (x - y) mod q for x, y in [0,q); the top bit flags a borrow.
    function automatic logic [width-1:0] mod_sub(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [width:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[width]) d = d + q_w1;
        return width'(d);
    endfunction

    // r/2 mod q: even r shifts, odd r becomes (r+q)/2 (q is odd).
    function automatic logic [width-1:0] halve(input logic [width-1:0] r);
        logic [width:0] s;
        s = {1'b0, r};
        if (r[0]) s = s + q_w1;
        return width'(s >> 1);
    endfunction

    // x*y mod q via Barrett reduction of the full 2*width-bit product.
    function automatic logic [width-1:0] mod_mul(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [pw-1:0]   p;
        logic [2*pw-1:0] pm;
        logic [pw-1:0]   qe;
        logic [pw-1:0]   r;
        p  = {{width{1'b0}}, x} * {{width{1'b0}}, y};
        pm = {{pw{1'b0}}, p} * {{pw{1'b0}}, barrett_m};
        qe = pw'(pm >> pw);
        r  = p - qe * q_pw;
        if (r >= q_pw) r = r - q_pw;
        if (r >= q_pw) r = r - q_pw;
        return width'(r);
    endfunction

    // Pipe advances when the output slot is empty or being taken.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage registers.
    logic             s1_valid, s1_sel, s1_scale;
    logic [width-1:0] s1_a, s1_b, s1_w;
    logic             s2_valid, s2_sel, s2_scale;
    logic [width-1:0] s2_x, s2_y, s2_w;
    logic             s3_valid, s3_sel, s3_scale;
    logic [width-1:0] s3_x, s3_p;

    assign busy = s1_valid || s2_valid || s3_valid || out_valid;

    // S1: capture operands and mode bits of the accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= 1'b0;
            s1_scale <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_w     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sel   <= select;
            s1_scale <= scale;
            s1_a     <= input_1;
            s1_b     <= input_2;
            s1_w     <= input_twiddle;
        end
    end

    // S2 datapath: INTT forms a+b and a-b before the multiply; NTT passes a, b.
    logic [width-1:0] s2_x_d, s2_y_d;
    always_comb begin
        s2_x_d = s1_a;
        s2_y_d = s1_b;
        if (s1_sel) begin
            s2_x_d = mod_add(s1_a, s1_b);
            s2_y_d = mod_sub(s1_a, s1_b);
        end
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sel   <= 1'b0;
            s2_scale <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_w     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sel   <= s1_sel;
            s2_scale <= s1_scale;
            s2_x     <= s2_x_d;
            s2_y     <= s2_y_d;
            s2_w     <= s1_w;
        end
    end

    // S3: modular multiply of the second operand by the twiddle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_sel   <= 1'b0;
            s3_scale <= 1'b0;
            s3_x     <= '0;
            s3_p     <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sel   <= s2_sel;
            s3_scale <= s2_scale;
            s3_x     <= s2_x;
            s3_p     <= mod_mul(s2_y, s2_w);
        end
    end

    // S4 datapath: NTT post add/sub, then optional halving of both results.
    logic [width-1:0] r1, r2, r1_out, r2_out;
    always_comb begin
        r1 = s3_x;
        r2 = s3_p;
        if (!s3_sel) begin
            r1 = mod_add(s3_x, s3_p);
            r2 = mod_sub(s3_x, s3_p);
        end
        r1_out = r1;
        r2_out = r2;
        if (s3_scale) begin
            r1_out = halve(r1);
            r2_out = halve(r2);
        end
    end

    // S4 output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            output_1  <= '0;
            output_2  <= '0;
        end else if (advance) begin
            out_valid <= s3_valid;
            output_1  <= r1_out;
            output_2  <= r2_out;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (out_valid && out_ready) begin
            beat_count <= beat_count + cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_radix_2_pipe.sv
// Directed and table-driven bench for radix_2_pipe.
module tb_radix_2_pipe;
    localparam int W  = 16;
    localparam int Q  = 12289;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  input_1, input_2, input_twiddle;
    logic          select, scale;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  output_1, output_2;
    logic          busy;
    logic [CW-1:0] beat_count;

    radix_2_pipe #(.width(W), .q(Q), .cnt_width(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .input_1(input_1), .input_2(input_2), .input_twiddle(input_twiddle),
        .select(select), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_1(output_1), .output_2(output_2),
        .busy(busy), .beat_count(beat_count)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b, w;
        logic         sel, scl;
        logic [W-1:0] e1, e2;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference butterfly in plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_bfly(input int a, input int b, input int w,
                                                 input bit sel, input bit scl);
        longint r1, r2, t;
        if (!sel) begin
            t  = (longint'(b) * w) % Q;
            r1 = (a + t) % Q;
            r2 = (a - t + Q) % Q;
        end else begin
            r1 = (a + b) % Q;
            r2 = (((a - b + Q) % Q) * longint'(w)) % Q;
        end
        if (scl) begin
            r1 = (r1 % 2 == 0) ? r1 / 2 : (r1 + Q) / 2;
            r2 = (r2 % 2 == 0) ? r2 / 2 : (r2 + Q) / 2;
        end
        return {W'(r1), W'(r2)};
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                         input logic sel, input logic scl);
        in_valid      = 1'b1;
        input_1       = a;
        input_2       = b;
        input_twiddle = w;
        select        = sel;
        scale         = scl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated beat: check exact latency and both results.
    task automatic send_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive(v.a, v.b, v.w, v.sel, v.scl);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_out1"}, output_1, v.e1);
        check({tag, "_out2"}, output_2, v.e2);
    endtask

    vec_t vecs[12];

    initial begin
        int sent, got, cyc, bad;
        logic take_in, stall_prev;
        logic [W-1:0] held1, held2;
        logic [W-1:0] ca, cb, cw;
        logic csel, cscl;
        logic [2*W-1:0] e;
        vec_t v;

        vecs[0]  = '{16'd5,     16'd3,     16'd2,     1'b0, 1'b0, 16'd11,    16'd12288};
        vecs[1]  = '{16'd5,     16'd3,     16'd2,     1'b1, 1'b0, 16'd8,     16'd4};
        vecs[2]  = '{16'd5,     16'd3,     16'd2,     1'b1, 1'b1, 16'd4,     16'd2};
        vecs[3]  = '{16'd4,     16'd3,     16'd1,     1'b1, 1'b1, 16'd6148,  16'd6145};
        vecs[4]  = '{16'd12288, 16'd1,     16'd1,     1'b0, 1'b0, 16'd0,     16'd12287};
        vecs[5]  = '{16'd0,     16'd0,     16'd12288, 1'b0, 1'b0, 16'd0,     16'd0};
        vecs[6]  = '{16'd0,     16'd12288, 16'd12288, 1'b0, 1'b0, 16'd1,     16'd12288};
        vecs[7]  = '{16'd12288, 16'd0,     16'd12288, 1'b1, 1'b0, 16'd12288, 16'd1};
        vecs[8]  = '{16'd100,   16'd200,   16'd300,   1'b0, 1'b1, 16'd5472,  16'd6917};
        vecs[9]  = '{16'd0,     16'd12288, 16'd12287, 1'b0, 1'b0, 16'd2,     16'd12287};
        vecs[10] = '{16'd3,     16'd5,     16'd1,     1'b1, 1'b0, 16'd8,     16'd12287};
        vecs[11] = '{16'd12288, 16'd12288, 16'd1,     1'b0, 1'b1, 16'd12288, 16'd0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        input_1 = '0;
        input_2 = '0;
        input_twiddle = '0;
        select = 1'b0;
        scale = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_output_1", output_1, 0);
        check("rst_output_2", output_2, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors.
        for (int i = 0; i < 12; i++) send_one(vecs[i], $sformatf("vec%0d", i));

        // Backpressure with random mixed-mode beats.
        do_reset();
        sent = 0; got = 0; cyc = 0;
        take_in = 1'b0; stall_prev = 1'b0;
        held1 = '0; held2 = '0;
        ca = '0; cb = '0; cw = '0; csel = 1'b0; cscl = 1'b0;
        while (got < 20 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (take_in) begin
                exp_q.push_back(ref_bfly(ca, cb, cw, csel, cscl));
                sent++;
                in_valid = 1'b0;
            end
            if (stall_prev) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_out1", output_1, held1);
                check("stall_out2", output_2, held2);
            end
            if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
                ca = W'($urandom_range(0, Q - 1));
                cb = W'($urandom_range(0, Q - 1));
                cw = W'($urandom_range(0, Q - 1));
                csel = 1'($urandom_range(0, 1));
                cscl = 1'($urandom_range(0, 1));
                drive(ca, cb, cw, csel, cscl);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", in_ready, !out_valid || out_ready);
            take_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bp%0d_out", got), {output_1, output_2}, e);
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held1 = output_1;
            held2 = output_2;
        end
        check("bp_beats_out", got, 20);
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_drained_valid", out_valid, 0);
        check("bp_drained_busy", busy, 0);
        check("bp_beat_count", beat_count, 20);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(W'(i + 7), W'(i + 2), 16'd9, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_beat_count", beat_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        check("mid_rst_no_stale", bad, 0);
        v = '{16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 16'd2, 16'd0};
        send_one(v, "post_rst");

        // Full throughput: 100 back-to-back beats.
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        bad = 0;
        got = 0;
        for (int j = 0; j < 110; j++) begin
            @(negedge clk);
            if (j > 0 && out_valid !== ((j >= 4) && (j < 104))) bad++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("tp_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tp%0d_out", got), {output_1, output_2}, e);
                end
                got++;
            end
            if (!in_ready) bad++;
            if (j < 100) begin
                ca = W'($urandom_range(0, Q - 1));
                cb = W'($urandom_range(0, Q - 1));
                cw = W'($urandom_range(0, Q - 1));
                csel = 1'($urandom_range(0, 1));
                cscl = 1'($urandom_range(0, 1));
                drive(ca, cb, cw, csel, cscl);
                exp_q.push_back(ref_bfly(ca, cb, cw, csel, cscl));
            end else begin
                in_valid = 1'b0;
            end
        end
        check("tp_valid_pattern", bad, 0);
        check("tp_beats_out", got, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
